// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode-to-execute stage: operand bypass, operand select, two-entry skid buffer
module id_ex_stage #(
  parameter int XLEN      = 64,
  parameter int ALUOP_LEN = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,

  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  logic [XLEN-1:0]      id_pc_i,
  input  logic [4:0]           id_rs1_idx_i,
  input  logic [4:0]           id_rs2_idx_i,
  input  logic [XLEN-1:0]      id_rs1_data_i,
  input  logic [XLEN-1:0]      id_rs2_data_i,
  input  logic [XLEN-1:0]      id_imm_i,
  input  logic [1:0]           id_src1_sel_i,
  input  logic [1:0]           id_src2_sel_i,
  input  logic [ALUOP_LEN-1:0] id_alu_op_i,
  input  logic [4:0]           id_rd_idx_i,
  input  logic                 id_rd_wen_i,
  input  logic                 id_is_branch_i,

  input  logic                 mem_fwd_valid_i,
  input  logic [4:0]           mem_fwd_rd_i,
  input  logic [XLEN-1:0]      mem_fwd_data_i,
  input  logic                 wb_fwd_valid_i,
  input  logic [4:0]           wb_fwd_rd_i,
  input  logic [XLEN-1:0]      wb_fwd_data_i,

  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output logic [XLEN-1:0]      ex_pc_o,
  output logic [XLEN-1:0]      alu_a_o,
  output logic [XLEN-1:0]      alu_b_o,
  output logic [ALUOP_LEN-1:0] alu_op_o,
  output logic [XLEN-1:0]      ex_rs2_data_o,
  output logic [XLEN-1:0]      ex_imm_o,
  output logic [4:0]           ex_rd_idx_o,
  output logic                 ex_rd_wen_o,
  output logic                 ex_is_branch_o
);

  // One captured micro-op: operands are already resolved and selected.
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      a;
    logic [XLEN-1:0]      b;
    logic [XLEN-1:0]      rs2;
    logic [XLEN-1:0]      imm;
    logic [ALUOP_LEN-1:0] op;
    logic [4:0]           rd;
    logic                 wen;
    logic                 br;
  } uop_t;

  // Occupancy: EMPTY = nothing held, ONE = main only, TWO = main + skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            ready_q;
  logic            ready_d;

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  uop_t            in_uop;
  uop_t            m_q;
  uop_t            s_q;

  logic            m_valid;
  logic            accept;
  logic            drain;
  logic            load_m_in;
  logic            load_m_skid;
  logic            load_s;

  assign m_valid = (state_q != ST_EMPTY);
  assign accept  = id_valid_i & ready_q;
  assign drain   = m_valid & ex_ready_i;

  // Bypass rs1: MEM beats WB beats regfile; x0 is never forwarded.
  always_comb begin
    rs1_fwd = id_rs1_data_i;
    if (id_rs1_idx_i != 5'd0 && mem_fwd_valid_i && mem_fwd_rd_i == id_rs1_idx_i) begin
      rs1_fwd = mem_fwd_data_i;
    end else if (id_rs1_idx_i != 5'd0 && wb_fwd_valid_i && wb_fwd_rd_i == id_rs1_idx_i) begin
      rs1_fwd = wb_fwd_data_i;
    end
  end

  // Bypass rs2 with the same priority; result also serves as store data.
  always_comb begin
    rs2_fwd = id_rs2_data_i;
    if (id_rs2_idx_i != 5'd0 && mem_fwd_valid_i && mem_fwd_rd_i == id_rs2_idx_i) begin
      rs2_fwd = mem_fwd_data_i;
    end else if (id_rs2_idx_i != 5'd0 && wb_fwd_valid_i && wb_fwd_rd_i == id_rs2_idx_i) begin
      rs2_fwd = wb_fwd_data_i;
    end
  end

  // Build the micro-op to capture, choosing ALU operands from the select codes.
  always_comb begin
    in_uop     = '0;
    in_uop.pc  = id_pc_i;
    in_uop.rs2 = rs2_fwd;
    in_uop.imm = id_imm_i;
    in_uop.op  = id_alu_op_i;
    in_uop.rd  = id_rd_idx_i;
    in_uop.wen = id_rd_wen_i;
    in_uop.br  = id_is_branch_i;
    case (id_src1_sel_i)
      2'd0:    in_uop.a = rs1_fwd;
      2'd1:    in_uop.a = id_pc_i;
      default: in_uop.a = '0;
    endcase
    case (id_src2_sel_i)
      2'd0:    in_uop.b = rs2_fwd;
      2'd1:    in_uop.b = id_imm_i;
      2'd2:    in_uop.b = XLEN'(4);
      default: in_uop.b = '0;
    endcase
  end

  // Occupancy state and registered ready; reset leaves the stage empty and ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Next occupancy; flush empties both entries and drops the same-cycle accept.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      state_d = ST_TWO;
          else if (drain && !accept) state_d = ST_EMPTY;
        end
        ST_TWO:   if (drain) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
    // Ready is only withheld while the skid entry will be occupied.
    ready_d = (state_d != ST_TWO);
  end

  // Steer captures: into main when it is free or leaving, into skid when main is stuck.
  always_comb begin
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    if (!flush_i) begin
      case (state_q)
        ST_EMPTY: load_m_in = accept;
        ST_ONE: begin
          load_m_in = accept & drain;
          load_s    = accept & ~drain;
        end
        ST_TWO:   load_m_skid = drain;
        default: begin
          load_m_in   = 1'b0;
          load_m_skid = 1'b0;
          load_s      = 1'b0;
        end
      endcase
    end
  end

  // Main entry: older instruction, drives the ALU; holds unless it loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
    end else if (load_m_skid) begin
      m_q <= s_q;
    end else if (load_m_in) begin
      m_q <= in_uop;
    end
  end

  // Skid entry: catches the younger instruction while main is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
    end else if (load_s) begin
      s_q <= in_uop;
    end
  end

  assign id_ready_o     = ready_q;
  assign ex_valid_o     = m_valid;
  assign ex_pc_o        = m_q.pc;
  assign alu_a_o        = m_q.a;
  assign alu_b_o        = m_q.b;
  assign alu_op_o       = m_q.op;
  assign ex_rs2_data_o  = m_q.rs2;
  assign ex_imm_o       = m_q.imm;
  assign ex_rd_idx_o    = m_q.rd;
  assign ex_rd_wen_o    = m_q.wen;
  assign ex_is_branch_o = m_q.br;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [63:0] id_pc_i;
  logic [4:0]  id_rs1_idx_i, id_rs2_idx_i;
  logic [63:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [1:0]  id_src1_sel_i, id_src2_sel_i;
  logic [4:0]  id_alu_op_i;
  logic [4:0]  id_rd_idx_i;
  logic        id_rd_wen_i, id_is_branch_i;
  logic        mem_fwd_valid_i, wb_fwd_valid_i;
  logic [4:0]  mem_fwd_rd_i, wb_fwd_rd_i;
  logic [63:0] mem_fwd_data_i, wb_fwd_data_i;
  logic        ex_valid_o, ex_ready_i;
  logic [63:0] ex_pc_o, alu_a_o, alu_b_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  alu_op_o, ex_rd_idx_o;
  logic        ex_rd_wen_o, ex_is_branch_o;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(64), .ALUOP_LEN(5)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_pc_i(id_pc_i),
    .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_src1_sel_i(id_src1_sel_i), .id_src2_sel_i(id_src2_sel_i),
    .id_alu_op_i(id_alu_op_i), .id_rd_idx_i(id_rd_idx_i), .id_rd_wen_i(id_rd_wen_i),
    .id_is_branch_i(id_is_branch_i),
    .mem_fwd_valid_i(mem_fwd_valid_i), .mem_fwd_rd_i(mem_fwd_rd_i), .mem_fwd_data_i(mem_fwd_data_i),
    .wb_fwd_valid_i(wb_fwd_valid_i), .wb_fwd_rd_i(wb_fwd_rd_i), .wb_fwd_data_i(wb_fwd_data_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_pc_o(ex_pc_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
    .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_rd_idx_o(ex_rd_idx_o), .ex_rd_wen_o(ex_rd_wen_o), .ex_is_branch_o(ex_is_branch_o)
  );

  typedef struct {
    logic [63:0] pc, a, b, rs2, imm;
    logic [4:0]  op, rd;
    logic        wen, br;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   drained = 0;
  bit   live = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] fwd(input logic [4:0] idx, input logic [63:0] rf);
    if (idx == 0) return rf;
    if (mem_fwd_valid_i && mem_fwd_rd_i == idx) return mem_fwd_data_i;
    if (wb_fwd_valid_i && wb_fwd_rd_i == idx) return wb_fwd_data_i;
    return rf;
  endfunction

  function automatic exp_t make_exp();
    exp_t e;
    logic [63:0] r1, r2;
    r1 = fwd(id_rs1_idx_i, id_rs1_data_i);
    r2 = fwd(id_rs2_idx_i, id_rs2_data_i);
    e.pc  = id_pc_i;
    e.a   = (id_src1_sel_i == 2'd0) ? r1 : (id_src1_sel_i == 2'd1) ? id_pc_i : 64'd0;
    e.b   = (id_src2_sel_i == 2'd0) ? r2 : (id_src2_sel_i == 2'd1) ? id_imm_i :
            (id_src2_sel_i == 2'd2) ? 64'd4 : 64'd0;
    e.rs2 = r2;
    e.imm = id_imm_i;
    e.op  = id_alu_op_i;
    e.rd  = id_rd_idx_i;
    e.wen = id_rd_wen_i;
    e.br  = id_is_branch_i;
    return e;
  endfunction

  // Model: an in-order FIFO of at most two instructions.
  always @(posedge clk) begin
    bit acc;
    if (rst) live <= 1'b1;
    if (rst || flush_i) begin
      q.delete();
    end else begin
      acc = id_valid_i && (q.size() < 2);
      if (q.size() > 0 && ex_ready_i) begin
        void'(q.pop_front());
        drained <= drained + 1;
      end
      if (acc) q.push_back(make_exp());
    end
  end

  // Every cycle: handshake flags and the oldest held instruction on the outputs.
  always @(negedge clk) begin
    if (live) begin
      chk("ex_valid", ex_valid_o, q.size() > 0);
      chk("id_ready", id_ready_o, q.size() < 2);
      if (q.size() > 0) begin
        chk("pc", ex_pc_o, q[0].pc);
        chk("alu_a", alu_a_o, q[0].a);
        chk("alu_b", alu_b_o, q[0].b);
        chk("alu_op", alu_op_o, q[0].op);
        chk("rs2_data", ex_rs2_data_o, q[0].rs2);
        chk("imm", ex_imm_o, q[0].imm);
        chk("rd_idx", ex_rd_idx_o, q[0].rd);
        chk("rd_wen", ex_rd_wen_o, q[0].wen);
        chk("is_branch", ex_is_branch_o, q[0].br);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input int k);
    id_pc_i        = 64'h1000 + 64'(4 * k);
    id_rs1_idx_i   = 5'd1;
    id_rs2_idx_i   = 5'd2;
    id_rs1_data_i  = 64'(k);
    id_rs2_data_i  = 64'(k + 100);
    id_imm_i       = 64'(10 * k);
    id_src1_sel_i  = 2'd0;
    id_src2_sel_i  = 2'd1;
    id_alu_op_i    = 5'(k);
    id_rd_idx_i    = 5'(k + 3);
    id_rd_wen_i    = 1'b1;
    id_is_branch_i = k[0];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int base;
    bit acc;
    rst = 1'b1; flush_i = 1'b0; ex_ready_i = 1'b0; id_valid_i = 1'b1;
    mem_fwd_valid_i = 1'b0; mem_fwd_rd_i = 5'd0; mem_fwd_data_i = 64'd0;
    wb_fwd_valid_i = 1'b0; wb_fwd_rd_i = 5'd0; wb_fwd_data_i = 64'd0;
    set_instr(7);

    // Reset with a valid instruction offered
    repeat (2) begin
      step();
      chk("rst_ex_valid", ex_valid_o, 1'b0);
      chk("rst_id_ready", id_ready_o, 1'b1);
      chk("rst_alu_a", alu_a_o, 64'd0);
    end
    rst = 1'b0; id_valid_i = 1'b0; ex_ready_i = 1'b1;
    step();

    // Streaming, one per cycle
    base = drained;
    for (int i = 0; i < 8; i++) begin
      set_instr(i);
      id_valid_i = 1'b1;
      step();
      chk("strm_alu_a", alu_a_o, 64'(i));
      chk("strm_alu_b", alu_b_o, 64'(10 * i));
      chk("strm_ready", id_ready_o, 1'b1);
      chk("strm_valid", ex_valid_o, 1'b1);
    end
    id_valid_i = 1'b0;
    step();
    chk("strm_count", drained - base, 8);

    // Backpressure: ex_ready low on cycles 2..4
    base = drained;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      ex_ready_i = !(c >= 2 && c <= 4);
      if (idx < 6) begin
        set_instr(20 + idx);
        id_valid_i = 1'b1;
      end else begin
        id_valid_i = 1'b0;
      end
      acc = id_valid_i && id_ready_o;
      step();
      if (acc) idx++;
      if (c == 2) begin
        chk("bp_ready_low", id_ready_o, 1'b0);
        chk("bp_pc_hold", ex_pc_o, 64'h1000 + 64'(4 * 21));
      end
      if (c == 4) begin
        chk("bp_pc_frozen", ex_pc_o, 64'h1000 + 64'(4 * 21));
        chk("bp_a_frozen", alu_a_o, 64'd21);
        chk("bp_ready_still_low", id_ready_o, 1'b0);
      end
      if (c == 5) begin
        chk("bp_pc_skid", ex_pc_o, 64'h1000 + 64'(4 * 22));
        chk("bp_ready_back", id_ready_o, 1'b1);
      end
    end
    id_valid_i = 1'b0;
    ex_ready_i = 1'b1;
    step();
    chk("bp_sent", idx, 6);
    chk("bp_count", drained - base, 6);

    // Forwarding: MEM beats WB
    set_instr(0);
    id_rs1_idx_i = 5'd5; id_rs2_idx_i = 5'd5;
    id_rs1_data_i = 64'h11; id_rs2_data_i = 64'h22;
    id_src1_sel_i = 2'd0; id_src2_sel_i = 2'd0;
    mem_fwd_valid_i = 1'b1; mem_fwd_rd_i = 5'd5; mem_fwd_data_i = 64'hAA;
    wb_fwd_valid_i = 1'b1; wb_fwd_rd_i = 5'd5; wb_fwd_data_i = 64'hBB;
    id_valid_i = 1'b1;
    step();
    chk("fwd_mem_a", alu_a_o, 64'hAA);
    chk("fwd_mem_rs2", ex_rs2_data_o, 64'hAA);
    chk("fwd_mem_b", alu_b_o, 64'hAA);
    // WB only
    mem_fwd_valid_i = 1'b0;
    step();
    chk("fwd_wb_a", alu_a_o, 64'hBB);
    chk("fwd_wb_rs2", ex_rs2_data_o, 64'hBB);
    // x0 never forwarded
    id_rs1_idx_i = 5'd0; id_rs2_idx_i = 5'd0;
    id_rs1_data_i = 64'd0; id_rs2_data_i = 64'd0;
    mem_fwd_valid_i = 1'b1; mem_fwd_rd_i = 5'd0;
    wb_fwd_rd_i = 5'd0;
    step();
    chk("fwd_x0_a", alu_a_o, 64'd0);
    chk("fwd_x0_rs2", ex_rs2_data_o, 64'd0);
    mem_fwd_valid_i = 1'b0; wb_fwd_valid_i = 1'b0;

    // Operand select: pc and constant 4, then zero/zero
    set_instr(1);
    id_pc_i = 64'h8000_0000;
    id_src1_sel_i = 2'd1; id_src2_sel_i = 2'd2;
    step();
    chk("sel_pc_a", alu_a_o, 64'h8000_0000);
    chk("sel_four_b", alu_b_o, 64'd4);
    set_instr(9);
    id_src1_sel_i = 2'd3; id_src2_sel_i = 2'd3;
    step();
    chk("sel_zero_a", alu_a_o, 64'd0);
    chk("sel_zero_b", alu_b_o, 64'd0);
    chk("sel_zero_rs2", ex_rs2_data_o, 64'd109);
    id_valid_i = 1'b0;
    step();

    // Flush with both entries full and a valid input
    ex_ready_i = 1'b0;
    set_instr(40); id_valid_i = 1'b1;
    step();
    set_instr(41);
    step();
    chk("fl_full_ready", id_ready_o, 1'b0);
    set_instr(42);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("fl_valid", ex_valid_o, 1'b0);
    chk("fl_ready", id_ready_o, 1'b1);
    set_instr(43);
    ex_ready_i = 1'b1;
    step();
    chk("fl_next_pc", ex_pc_o, 64'h1000 + 64'(4 * 43));
    chk("fl_next_valid", ex_valid_o, 1'b1);
    id_valid_i = 1'b0;
    step();
    chk("end_empty", ex_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
